// File: rtl/sv32_translate_tlb.sv
// Sv32 address translator with a fully-associative TLB; bare/M/hit respond in 1 cycle, a miss walks then refills.
// Latency: 1 cycle on hit, walk_ready + 2 on miss. No backpressure: requester holds valid until the ready pulse. Optional SV32_AD_CHECK_EN adds Svade A/D faults.
module sv32_translate_tlb #(
  parameter int TLB_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] address,
  input  logic [1:0]  access_type,
  input  logic [1:0]  privilege_mode,
  input  logic [31:0] mstatus,
  input  logic [31:0] satp,
  input  logic        tlb_flush,
  output logic [33:0] physical_address,
  output logic        page_fault,
  output logic        walk_valid,
  input  logic        walk_ready,
  input  logic [31:0] walk_pte,
  input  logic        walk_level
);

  localparam int PTR_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
`ifdef SV32_AD_CHECK_EN
  localparam bit AD_CHECK = 1'b1;
`else
  localparam bit AD_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WALK, FILL} state_t;

  typedef struct packed {
    logic        vld;
    logic [19:0] tag;
    logic        lvl;
    logic [21:0] ppn;
    logic        r, w, x, u, a, d;
  } tlb_entry_t;

  state_t           state_q, state_d;
  tlb_entry_t       tlb_q [TLB_ENTRIES];
  tlb_entry_t       hit_e;
  logic             hit;
  logic [PTR_W-1:0] ptr_q;
  logic [31:0]      pte_q;
  logic             lvl_q;
  logic             flush_seen_q;
  logic [1:0]       acc;
  logic [1:0]       eff_priv;
  logic             resp_vld, resp_fault, fill_en;
  logic [33:0]      resp_pa;

  function automatic logic perm_fault(
    input logic v, input logic r, input logic w, input logic x, input logic u,
    input logic a, input logic d, input logic lvl, input logic [9:0] ppn0,
    input logic [1:0] at, input logic [1:0] priv, input logic sum, input logic mxr);
    logic f;
    f = !v || (w && !r) || (lvl && ppn0 != 10'd0);
    case (at)
      2'd1:    f = f || !w;
      2'd2:    f = f || !x;
      default: f = f || !(r || (mxr && x));
    endcase
    if (priv == 2'b00 && !u) f = 1'b1;
    if (priv == 2'b01 && u && (at == 2'd2 || !sum)) f = 1'b1;
    if (AD_CHECK && (!a || (at == 2'd1 && !d))) f = 1'b1;
    return f;
  endfunction

  function automatic logic [33:0] xlate(input logic lvl, input logic [21:0] ppn, input logic [31:0] va);
    return lvl ? {ppn[21:10], va[21:0]} : {ppn, va[11:0]};
  endfunction

  assign walk_valid = (state_q == WALK);

  always_comb begin
    state_d    = state_q;
    resp_vld   = 1'b0;
    resp_fault = 1'b0;
    resp_pa    = '0;
    fill_en    = 1'b0;
    hit        = 1'b0;
    hit_e      = '0;
    acc        = (access_type == 2'd3) ? 2'd0 : access_type;
    eff_priv   = (acc != 2'd2 && mstatus[17]) ? mstatus[12:11] : privilege_mode;

    // First match wins; a flush in the same cycle forces a miss.
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (!hit && tlb_q[i].vld &&
          (tlb_q[i].lvl ? (tlb_q[i].tag[19:10] == address[31:22]) : (tlb_q[i].tag == address[31:12]))) begin
        hit   = 1'b1;
        hit_e = tlb_q[i];
      end
    end
    if (tlb_flush) hit = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid && !ready) begin
          if (eff_priv == 2'b11 || !satp[31]) begin
            resp_vld = 1'b1;
            resp_pa  = {2'b00, address};
          end else if (hit) begin
            resp_vld   = 1'b1;
            resp_fault = perm_fault(1'b1, hit_e.r, hit_e.w, hit_e.x, hit_e.u, hit_e.a, hit_e.d,
                                    hit_e.lvl, hit_e.ppn[9:0], acc, eff_priv, mstatus[18], mstatus[19]);
            resp_pa    = resp_fault ? 34'h3_FFFF_FFFF : xlate(hit_e.lvl, hit_e.ppn, address);
          end else begin
            state_d = WALK;
          end
        end
      end
      WALK: begin
        if (walk_ready) state_d = FILL;
      end
      FILL: begin
        resp_vld   = 1'b1;
        resp_fault = perm_fault(pte_q[0], pte_q[1], pte_q[2], pte_q[3], pte_q[4], pte_q[6], pte_q[7],
                                lvl_q, pte_q[19:10], acc, eff_priv, mstatus[18], mstatus[19]);
        resp_pa    = resp_fault ? 34'h3_FFFF_FFFF : xlate(lvl_q, pte_q[31:10], address);
        fill_en    = !resp_fault && !flush_seen_q && !tlb_flush;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= IDLE;
      ready            <= 1'b0;
      page_fault       <= 1'b0;
      physical_address <= '0;
      ptr_q            <= '0;
      pte_q            <= '0;
      lvl_q            <= 1'b0;
      flush_seen_q     <= 1'b0;
      for (int i = 0; i < TLB_ENTRIES; i++) tlb_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ready      <= resp_vld;
      page_fault <= resp_fault;
      if (resp_vld) physical_address <= resp_pa;

      if (state_q == WALK && walk_ready) begin
        pte_q <= walk_pte;
        lvl_q <= walk_level;
      end

      if (state_q == IDLE)  flush_seen_q <= 1'b0;
      else if (tlb_flush)   flush_seen_q <= 1'b1;

      if (tlb_flush) begin
        for (int i = 0; i < TLB_ENTRIES; i++) tlb_q[i].vld <= 1'b0;
      end else if (fill_en) begin
        tlb_q[ptr_q] <= '{vld: 1'b1, tag: address[31:12], lvl: lvl_q, ppn: pte_q[31:10],
                          r: pte_q[1], w: pte_q[2], x: pte_q[3], u: pte_q[4], a: pte_q[6], d: pte_q[7]};
        ptr_q <= (ptr_q == PTR_W'(TLB_ENTRIES - 1)) ? '0 : ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sv32_translate_tlb.sv
// Directed bench for sv32_translate_tlb: acts as the page-table walker and checks latency, PA, faults and walk counts.
module tb_sv32_translate_tlb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic        ready;
  logic [31:0] address;
  logic [1:0]  access_type;
  logic [1:0]  privilege_mode;
  logic [31:0] mstatus;
  logic [31:0] satp;
  logic        tlb_flush;
  logic [33:0] physical_address;
  logic        page_fault;
  logic        walk_valid;
  logic        walk_ready;
  logic [31:0] walk_pte;
  logic        walk_level;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          r_lat, r_walks;
  logic [33:0] r_pa;
  logic        r_fault;

  localparam logic [31:0] SV32 = 32'h8000_0000;
  localparam logic [33:0] FPA  = 34'h3_FFFF_FFFF;

  sv32_translate_tlb #(.TLB_ENTRIES(4)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .ready(ready), .address(address),
    .access_type(access_type), .privilege_mode(privilege_mode), .mstatus(mstatus), .satp(satp),
    .tlb_flush(tlb_flush), .physical_address(physical_address), .page_fault(page_fault),
    .walk_valid(walk_valid), .walk_ready(walk_ready), .walk_pte(walk_pte), .walk_level(walk_level)
  );

  always #5 clk = ~clk;

  // Issue one request, answer any walk two cycles after walk_valid, record the response.
  task automatic req(input logic [31:0] a, input logic [1:0] at, input logic [1:0] priv,
                     input logic [31:0] pte, input logic lvl, input logic flush_walk);
    int wcnt;
    address = a; access_type = at; privilege_mode = priv; valid = 1'b1;
    r_lat = 0; r_walks = 0; wcnt = 0;
    do begin
      @(posedge clk); #1;
      r_lat++;
      walk_ready = 1'b0;
      tlb_flush  = 1'b0;
      if (walk_valid) begin
        wcnt++;
        if (flush_walk && wcnt == 1) tlb_flush = 1'b1;
        if (wcnt == 2) begin
          walk_ready = 1'b1; walk_pte = pte; walk_level = lvl;
          r_walks++; wcnt = 0;
        end
      end
    end while (!ready && r_lat < 40);
    if (!ready) begin
      n_tests++; n_fail++;
      $display("FAIL req_timeout: addr=%h no ready after %0d cycles", a, r_lat);
    end
    r_pa = physical_address; r_fault = page_fault;
    valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({ready, page_fault, walk_valid, physical_address} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b pf=%b wv=%b pa=%h, want all zero",
               ready, page_fault, walk_valid, physical_address);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_bare_mmode;
    satp = SV32; mstatus = 32'h0;
    req(32'h8000_1234, 2'd0, 2'b11, 32'h0, 1'b0, 1'b0);
    n_tests++;
    if (r_pa !== 34'h0_8000_1234 || r_fault !== 1'b0 || r_lat != 1 || r_walks != 0) begin
      n_fail++;
      $display("FAIL mmode_load: pa=%h pf=%b lat=%0d walks=%0d, want 080001234 0 1 0", r_pa, r_fault, r_lat, r_walks);
    end
    satp = 32'h0;
    req(32'h1234_5678, 2'd0, 2'b01, 32'h0, 1'b0, 1'b0);
    n_tests++;
    if (r_pa !== 34'h0_1234_5678 || r_fault !== 1'b0 || r_lat != 1 || r_walks != 0) begin
      n_fail++;
      $display("FAIL bare_load: pa=%h pf=%b lat=%0d walks=%0d, want 012345678 0 1 0", r_pa, r_fault, r_lat, r_walks);
    end
    satp = SV32;
  endtask

  task automatic test_miss_hit;
    req(32'h4000_0ABC, 2'd0, 2'b01, 32'h2000_04CF, 1'b0, 1'b0);
    n_tests++;
    if (r_pa !== 34'h0_8000_1ABC || r_fault !== 1'b0 || r_lat != 4 || r_walks != 1) begin
      n_fail++;
      $display("FAIL miss_load: pa=%h pf=%b lat=%0d walks=%0d, want 080001abc 0 4 1", r_pa, r_fault, r_lat, r_walks);
    end
    req(32'h4000_0ABC, 2'd0, 2'b01, 32'h0, 1'b0, 1'b0);
    n_tests++;
    if (r_pa !== 34'h0_8000_1ABC || r_fault !== 1'b0 || r_lat != 1 || r_walks != 0) begin
      n_fail++;
      $display("FAIL hit_load: pa=%h pf=%b lat=%0d walks=%0d, want 080001abc 0 1 0", r_pa, r_fault, r_lat, r_walks);
    end
    req(32'h4000_0010, 2'd2, 2'b01, 32'h0, 1'b0, 1'b0);
    n_tests++;
    if (r_pa !== 34'h0_8000_1010 || r_fault !== 1'b0 || r_lat != 1 || r_walks != 0) begin
      n_fail++;
      $display("FAIL hit_exec: pa=%h pf=%b lat=%0d walks=%0d, want 080001010 0 1 0", r_pa, r_fault, r_lat, r_walks);
    end
    // M-mode with MPRV=1, MPP=S: loads translate through the TLB, fetches stay bare.
    mstatus = 32'h0002_0800;
    req(32'h4000_0ABC, 2'd0, 2'b11, 32'h0, 1'b0, 1'b0);
    n_tests++;
    if (r_pa !== 34'h0_8000_1ABC || r_fault !== 1'b0 || r_lat != 1) begin
      n_fail++;
      $display("FAIL mprv_load: pa=%h pf=%b lat=%0d, want 080001abc 0 1", r_pa, r_fault, r_lat);
    end
    req(32'h4000_0ABC, 2'd2, 2'b11, 32'h0, 1'b0, 1'b0);
    n_tests++;
    if (r_pa !== 34'h0_4000_0ABC || r_fault !== 1'b0 || r_lat != 1) begin
      n_fail++;
      $display("FAIL mprv_exec: pa=%h pf=%b lat=%0d, want 040000abc 0 1", r_pa, r_fault, r_lat);
    end
    mstatus = 32'h0;
  endtask

  task automatic test_user_fault;
    for (int k = 0; k < 2; k++) begin
      req(32'h5000_0000, 2'd1, 2'b00, 32'h2000_04CF, 1'b0, 1'b0);
      n_tests++;
      if (r_pa !== FPA || r_fault !== 1'b1 || r_walks != 1) begin
        n_fail++;
        $display("FAIL user_store_%0d: pa=%h pf=%b walks=%0d, want 3ffffffff 1 1", k, r_pa, r_fault, r_walks);
      end
    end
    req(32'h6000_0000, 2'd0, 2'b01, 32'h2000_04DF, 1'b0, 1'b0);
    n_tests++;
    if (r_pa !== FPA || r_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL s_load_upage_nosum: pa=%h pf=%b, want 3ffffffff 1", r_pa, r_fault);
    end
    mstatus = 32'h0004_0000;
    req(32'h6000_0000, 2'd0, 2'b01, 32'h2000_04DF, 1'b0, 1'b0);
    n_tests++;
    if (r_pa !== 34'h0_8000_1000 || r_fault !== 1'b0 || r_walks != 1) begin
      n_fail++;
      $display("FAIL s_load_upage_sum: pa=%h pf=%b walks=%0d, want 080001000 0 1", r_pa, r_fault, r_walks);
    end
    req(32'h6000_0004, 2'd2, 2'b01, 32'h0, 1'b0, 1'b0);
    n_tests++;
    if (r_pa !== FPA || r_fault !== 1'b1 || r_lat != 1) begin
      n_fail++;
      $display("FAIL s_exec_upage_hit: pa=%h pf=%b lat=%0d, want 3ffffffff 1 1", r_pa, r_fault, r_lat);
    end
    mstatus = 32'h0;
  endtask

  task automatic test_superpage;
    req(32'h0012_3456, 2'd0, 2'b01, 32'h2000_04CF, 1'b1, 1'b0);
    n_tests++;
    if (r_pa !== FPA || r_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL super_misaligned: pa=%h pf=%b, want 3ffffffff 1", r_pa, r_fault);
    end
    req(32'h0012_3456, 2'd0, 2'b01, 32'h2000_00CF, 1'b1, 1'b0);
    n_tests++;
    if (r_pa !== 34'h0_8012_3456 || r_fault !== 1'b0 || r_walks != 1) begin
      n_fail++;
      $display("FAIL super_fill: pa=%h pf=%b walks=%0d, want 080123456 0 1", r_pa, r_fault, r_walks);
    end
    req(32'h003F_FFFC, 2'd0, 2'b01, 32'h0, 1'b0, 1'b0);
    n_tests++;
    if (r_pa !== 34'h0_803F_FFFC || r_fault !== 1'b0 || r_lat != 1) begin
      n_fail++;
      $display("FAIL super_hit: pa=%h pf=%b lat=%0d, want 0803ffffc 0 1", r_pa, r_fault, r_lat);
    end
  endtask

  task automatic test_access3_mxr;
    req(32'h7100_0000, 2'd3, 2'b01, 32'h2000_04C9, 1'b0, 1'b0);
    n_tests++;
    if (r_pa !== FPA || r_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL type3_load_xonly: pa=%h pf=%b, want 3ffffffff 1", r_pa, r_fault);
    end
    req(32'h7100_0000, 2'd2, 2'b01, 32'h2000_04C9, 1'b0, 1'b0);
    n_tests++;
    if (r_pa !== 34'h0_8000_1000 || r_fault !== 1'b0 || r_walks != 1) begin
      n_fail++;
      $display("FAIL exec_xonly: pa=%h pf=%b walks=%0d, want 080001000 0 1", r_pa, r_fault, r_walks);
    end
    mstatus = 32'h0008_0000;
    req(32'h7100_0008, 2'd3, 2'b01, 32'h0, 1'b0, 1'b0);
    n_tests++;
    if (r_pa !== 34'h0_8000_1008 || r_fault !== 1'b0 || r_lat != 1) begin
      n_fail++;
      $display("FAIL mxr_load_hit: pa=%h pf=%b lat=%0d, want 080001008 0 1", r_pa, r_fault, r_lat);
    end
    mstatus = 32'h0;
  endtask

  task automatic test_eviction_flush;
    for (int i = 0; i < 5; i++) req(32'h1000_0000 + 32'(i) * 32'h1000, 2'd0, 2'b01, 32'h2000_04CF, 1'b0, 1'b0);
    req(32'h1000_4000, 2'd0, 2'b01, 32'h0, 1'b0, 1'b0);
    n_tests++;
    if (r_walks != 0 || r_lat != 1) begin
      n_fail++;
      $display("FAIL evict_last_hits: walks=%0d lat=%0d, want 0 1", r_walks, r_lat);
    end
    req(32'h1000_0000, 2'd0, 2'b01, 32'h2000_04CF, 1'b0, 1'b0);
    n_tests++;
    if (r_walks != 1 || r_pa !== 34'h0_8000_1000) begin
      n_fail++;
      $display("FAIL evict_first_walks: walks=%0d pa=%h, want 1 080001000", r_walks, r_pa);
    end
    tlb_flush = 1'b1;
    @(posedge clk); #1;
    tlb_flush = 1'b0;
    req(32'h1000_4000, 2'd0, 2'b01, 32'h2000_04CF, 1'b0, 1'b0);
    n_tests++;
    if (r_walks != 1) begin
      n_fail++;
      $display("FAIL flush_miss: walks=%0d, want 1", r_walks);
    end
    req(32'h3000_0000, 2'd0, 2'b01, 32'h2000_04CF, 1'b0, 1'b1);
    n_tests++;
    if (r_pa !== 34'h0_8000_1000 || r_fault !== 1'b0 || r_walks != 1) begin
      n_fail++;
      $display("FAIL flush_in_walk_resp: pa=%h pf=%b walks=%0d, want 080001000 0 1", r_pa, r_fault, r_walks);
    end
    req(32'h3000_0000, 2'd0, 2'b01, 32'h2000_04CF, 1'b0, 1'b0);
    n_tests++;
    if (r_walks != 1) begin
      n_fail++;
      $display("FAIL flush_in_walk_nofill: walks=%0d, want 1", r_walks);
    end
  endtask

  task automatic test_ad;
    req(32'h7000_0000, 2'd0, 2'b01, 32'h2000_040F, 1'b0, 1'b0);
    n_tests++;
`ifdef SV32_AD_CHECK_EN
    if (r_pa !== FPA || r_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL a_clear_load: pa=%h pf=%b, want 3ffffffff 1", r_pa, r_fault);
    end
`else
    if (r_pa !== 34'h0_8000_1000 || r_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL a_clear_load: pa=%h pf=%b, want 080001000 0", r_pa, r_fault);
    end
`endif
  endtask

  task automatic test_reset_mid_walk;
    address = 32'h2200_0000; access_type = 2'd0; privilege_mode = 2'b01; valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (walk_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL walk_started: wv=%b, want 1", walk_valid);
    end
    resetn = 1'b0; valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    n_tests++;
    if (walk_valid !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_walk: wv=%b rdy=%b, want 0 0", walk_valid, ready);
    end
    walk_ready = 1'b1; walk_pte = 32'h2000_04CF; walk_level = 1'b0;
    @(posedge clk); #1;
    walk_ready = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (walk_valid !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_walk_ready: wv=%b rdy=%b, want 0 0", walk_valid, ready);
    end
  endtask

  initial begin
    valid = 1'b0; address = '0; access_type = '0; privilege_mode = 2'b11;
    mstatus = '0; satp = SV32; tlb_flush = 1'b0;
    walk_ready = 1'b0; walk_pte = '0; walk_level = 1'b0;
    test_reset;
    test_bare_mmode;
    test_miss_hit;
    test_user_fault;
    test_superpage;
    test_access3_mxr;
    test_eviction_flush;
    test_ad;
    test_reset_mid_walk;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sv32_translate_tlb.md
# sv32_translate_tlb

Parametrised Sv32 data/instruction address translator with an internal fully-associative TLB. It sits between the core's memory-access path and the shared Sv32 page-table walker. TLB hits resolve without a walk. Misses issue one walk request and refill the TLB. It adds execute-access checks, superpage support, satp bare mode and flush handling.

## Interface
- `TLB_ENTRIES`, 4: number of TLB entries, ≥1; replacement pointer width is `$clog2(TLB_ENTRIES)`, minimum 1.
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `valid` in 1: translation request.
- `ready` out 1: one-cycle response pulse.
- `address` in 32: virtual address.
- `access_type` in 2: 0 load, 1 store, 2 execute; 3 is treated as load.
- `privilege_mode` in 2: current privilege.
- `mstatus` in 32: MPRV, MPP, SUM, MXR fields used.
- `satp` in 32: bit 31 = MODE; 0 means bare.
- `tlb_flush` in 1: invalidate all entries (sfence.vma).
- `physical_address` out 34: translated address.
- `page_fault` out 1: valid with `ready`.
- `walk_valid` out 1: walk request.
- `walk_ready` in 1: walk done; `walk_pte` and `walk_level` are valid in this cycle.
- `walk_pte` in 32: leaf PTE.
- `walk_level` in 1: 1 = 4 MiB superpage leaf, 0 = 4 KiB leaf.

## Operation
- States:
  - IDLE: accepting requests.
  - WALK: waiting on the page-table walker.
  - FILL: checking the walked PTE and refilling the TLB.
- Reset values:
  - `ready`, `page_fault`, `walk_valid` = 0; `physical_address` = 0.
  - All TLB valid bits = 0; replacement pointer = 0; state = IDLE.
- Effective privilege:
  - For loads and stores, use `MPP` if `MPRV` = 1; otherwise use `privilege_mode`.
  - Execute accesses always use `privilege_mode`.
- IDLE, when `valid && !ready`:
  - Effective privilege is M, or `satp[31]` = 0: `physical_address` = {2'b0, address}, no fault, respond.
  - Otherwise, look up the TLB. An entry matches when it is valid, and its tag matches either VPN[19:0] (4 KiB entry) or VPN1 = address[31:22] (superpage entry).
  - Hit: run the permission check on the cached bits and respond.
  - Miss: go to WALK.
- WALK:
  - `walk_valid` = 1.
  - On `walk_ready`, capture the PTE and level, then go to FILL.
- FILL:
  - Run the permission check.
  - If there is no fault, write the entry at the replacement pointer. The entry holds tag, level, PPN, and the R, W, X, U, A, D bits. The pointer then increments and wraps from `TLB_ENTRIES`−1 to 0.
  - Faulting PTEs are never cached.
  - Respond, then go to IDLE.
- Permission check (also re-applied on every hit, because privilege and mstatus can change). A fault is raised if any of these holds:
  - V = 0 (walk only).
  - W = 1 and R = 0.
  - Superpage leaf with PPN0 ≠ 0.
  - Load: not (R, or MXR and X).
  - Store: W = 0.
  - Execute: X = 0.
  - U-mode access to a page with U = 0.
  - S-mode execute of a page with U = 1.
  - S-mode load/store of a page with U = 1 while SUM = 0.
- Physical address:
  - 4 KiB page: {PTE[31:10], address[11:0]}.
  - Superpage: {PTE[31:20], address[21:0]}.
  - On fault: 34'h3_FFFF_FFFF.
- `tlb_flush`:
  - Clears all valid bits at the next edge.
  - A lookup in the same cycle is treated as a miss.
  - A flush during WALK or FILL suppresses that fill; the response is still returned.

## Timing
- Bare, M-mode and TLB-hit requests: `ready` is asserted 1 cycle after the request is accepted.
- Miss:
  - `walk_valid` rises 1 cycle after acceptance and holds until `walk_ready`.
  - `ready` is asserted 2 cycles after `walk_ready`: one cycle to capture into FILL, one to register the response.
- `ready` is a single-cycle pulse.
- The requester holds `valid`, `address` and `access_type` stable until `ready`.
- A new request is accepted no earlier than the cycle after `ready`.
- Outputs are registered, except `walk_valid`, which is decoded from state.
- Reset asserted mid-walk: return to IDLE at the edge and drop `walk_valid`. The walker's `walk_ready` is ignored in IDLE.

## Configuration
- `SV32_AD_CHECK_EN`:
  - Defined: additionally fault when A = 0, or when the access is a store and D = 0. The Svade behaviour applies on both hit and fill.
  - Undefined: A and D bits are ignored. They are still stored in the TLB but never cause a fault.

## Test plan
- M-mode load of 0x8000_1234 → `ready` at +1 cycle, PA = 0x0_8000_1234, no fault, `walk_valid` never asserted.
- S-mode load of 0x4000_0ABC, miss; walk returns PTE 0x2000_04CF (V, R, W, X, A, D), level 0 → PA = 0x0_8000_1ABC. A repeat of the same request hits: `ready` at +1, no walk.
- U-mode store to a page with U = 0 → `page_fault` = 1, PA = 0x3_FFFF_FFFF. A refetch walks again, because the faulting PTE was not cached.
- Superpage: walk_level = 1, PTE PPN0 ≠ 0 → fault. With PPN0 = 0 and PTE[31:20] = 0x200, address 0x0012_3456 → PA = 0x0_8012_3456.
- Fill `TLB_ENTRIES`+1 distinct pages → entry 0 is evicted and the first page walks again. Then `tlb_flush` → all pages miss.
- Load of a page with A = 0 → fault when `SV32_AD_CHECK_EN` is defined; PA translated when it is undefined.
